// File: rtl/write_ptr_ctrl.sv
// Write-side pointer/flag controller for the dual-clock sample FIFO.
// Keeps binary/Gray write pointers, synchronizes the read Gray pointer and derives full, level and overflow.
module write_ptr_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int AF_THRESH = 2**ADDR_SIZE-4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   rd_ptr_i,
  input  logic                 wr_i,
  input  logic                 clr_ovf_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] waddr_o,
  output logic                 wen_o,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 overflow_o
);

  localparam logic [ADDR_SIZE:0] AF_THRESH_C = (ADDR_SIZE+1)'(AF_THRESH);

  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE-1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_SIZE:0] wbin_r;
  logic [ADDR_SIZE:0] wgray_r;
  logic [ADDR_SIZE:0] rq1_r;
  logic [ADDR_SIZE:0] rq2_r;
  logic               full_r;
  logic               almost_full_r;
  logic [ADDR_SIZE:0] level_r;
  logic               overflow_r;

  logic               acc_s;
  logic [ADDR_SIZE:0] wbin_n_s;
  logic [ADDR_SIZE:0] wgray_n_s;
  logic [ADDR_SIZE:0] rbin_s;
  logic [ADDR_SIZE:0] level_n_s;
  logic               full_n_s;

  assign acc_s     = wr_i & ~full_r;
  assign wbin_n_s  = wbin_r + {{ADDR_SIZE{1'b0}}, acc_s};
  assign wgray_n_s = (wbin_n_s >> 1) ^ wbin_n_s;
  assign rbin_s    = gray2bin(rq2_r);
  assign level_n_s = wbin_n_s - rbin_s;
  // Full when the next write pointer sits one lap ahead of the synchronized read pointer.
  assign full_n_s  = (wgray_n_s == {~rq2_r[ADDR_SIZE:ADDR_SIZE-1], rq2_r[ADDR_SIZE-2:0]});

  // Pointer, synchronizer and flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wbin_r        <= '0;
      wgray_r       <= '0;
      rq1_r         <= '0;
      rq2_r         <= '0;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      level_r       <= '0;
      overflow_r    <= 1'b0;
    end else begin
      wbin_r        <= wbin_n_s;
      wgray_r       <= wgray_n_s;
      rq1_r         <= rd_ptr_i;
      rq2_r         <= rq1_r;
      full_r        <= full_n_s;
      almost_full_r <= (level_n_s >= AF_THRESH_C);
      level_r       <= level_n_s;
      overflow_r    <= (wr_i & full_r) | (overflow_r & ~clr_ovf_i);
    end
  end

  assign ptr_o         = wgray_r;
  assign waddr_o       = wbin_r[ADDR_SIZE-1:0];
  // Gated by reset so every output reads 0 while reset is held.
  assign wen_o         = acc_s & rst_i;
  assign full_o        = full_r;
  assign almost_full_o = almost_full_r;
  assign level_o       = level_r;
  assign overflow_o    = overflow_r;

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Self-checking bench for write_ptr_ctrl (ADDR_SIZE=3, AF_THRESH=6) against a count-based FIFO model.
module tb_write_ptr_ctrl;
  localparam int AS    = 3;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          wr_i = 1'b0;
  logic          clr_ovf_i = 1'b0;
  logic [AS:0]   rd_ptr_i = '0;
  logic [AS:0]   ptr_o;
  logic [AS-1:0] waddr_o;
  logic          wen_o;
  logic          full_o;
  logic          almost_full_o;
  logic [AS:0]   level_o;
  logic          overflow_o;

  int compared = 0;
  int mismatched = 0;

  // Model: total accepted writes, total reads issued, reads visible to the writer after two edges.
  int wcount = 0;
  int rcount = 0;
  int seen_d1 = 0;
  int seen_d2 = 0;
  int level_m = 0;
  bit full_m = 1'b0;
  bit af_m = 1'b0;
  bit ovf_m = 1'b0;

  always #5 clk_i = ~clk_i;

  write_ptr_ctrl #(.ADDR_SIZE(AS), .AF_THRESH(AFT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_ptr_i(rd_ptr_i), .wr_i(wr_i), .clr_ovf_i(clr_ovf_i),
    .ptr_o(ptr_o), .waddr_o(waddr_o), .wen_o(wen_o), .full_o(full_o),
    .almost_full_o(almost_full_o), .level_o(level_o), .overflow_o(overflow_o)
  );

  function automatic logic [AS:0] gray(input int n);
    logic [AS:0] b;
    b = AS'(0) + (AS+1)'(n % (2*DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ptr_o",         32'(ptr_o),         32'(gray(wcount)));
    chk("waddr_o",       32'(waddr_o),       32'(wcount % DEPTH));
    chk("full_o",        32'(full_o),        32'(full_m));
    chk("almost_full_o", 32'(almost_full_o), 32'(af_m));
    chk("level_o",       32'(level_o),       32'(level_m));
    chk("overflow_o",    32'(overflow_o),    32'(ovf_m));
    chk("wen_o",         32'(wen_o),         32'(wr_i && !full_m));
  endtask

  task automatic model_reset();
    wcount = 0; rcount = 0; seen_d1 = 0; seen_d2 = 0;
    level_m = 0; full_m = 1'b0; af_m = 1'b0; ovf_m = 1'b0;
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model on the rising edge.
  task automatic cycle(input bit wr, input bit clr, input bit rd);
    bit acc;
    @(negedge clk_i);
    if (rd && rcount < wcount) rcount++;
    wr_i = wr; clr_ovf_i = clr; rd_ptr_i = gray(rcount);
    #1;
    check_all();
    @(posedge clk_i);
    acc    = wr_i && !full_m;
    ovf_m  = (wr_i && full_m) || (ovf_m && !clr_ovf_i);
    wcount = wcount + int'(acc);
    level_m = wcount - seen_d2;
    seen_d2 = seen_d1;
    seen_d1 = rcount;
    full_m = (level_m == DEPTH);
    af_m   = (level_m >= AFT);
  endtask

  task automatic async_reset();
    #2;
    wr_i = 1'b1;
    rst_i = 1'b0;
    #1;
    chk("rst ptr_o",    32'(ptr_o),         32'd0);
    chk("rst waddr_o",  32'(waddr_o),       32'd0);
    chk("rst wen_o",    32'(wen_o),         32'd0);
    chk("rst full_o",   32'(full_o),        32'd0);
    chk("rst af_o",     32'(almost_full_o), 32'd0);
    chk("rst level_o",  32'(level_o),       32'd0);
    chk("rst ovf_o",    32'(overflow_o),    32'd0);
    model_reset();
    rd_ptr_i = '0;
    @(negedge clk_i);
    wr_i = 1'b0; clr_ovf_i = 1'b0;
    rst_i = 1'b1;
  endtask

  initial begin
    wr_i = 1'b1;
    #1;
    chk("init wen_o",  32'(wen_o),   32'd0);
    chk("init ptr_o",  32'(ptr_o),   32'd0);
    chk("init level",  32'(level_o), 32'd0);
    @(negedge clk_i);
    wr_i = 1'b0;
    rst_i = 1'b1;

    // Fill to full, then one dropped write.
    repeat (9) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("full ptr_o", 32'(ptr_o), 32'b1100);
    chk("full level", 32'(level_o), 32'd8);

    // Overflow clear alone, then clear together with a write while full.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("ovf set wins", 32'(overflow_o), 32'd1);
    cycle(1'b0, 1'b1, 1'b0);

    // One read releases full after three edges; next write lands at address 0.
    cycle(1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("release level", 32'(level_o), 32'd7);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Mid-stream reset, then almost-full threshold.
    async_reset();
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("af level", 32'(level_o), 32'd6);

    // Wrap with the reader trailing closely.
    async_reset();
    repeat (20) cycle(1'b1, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b1);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      cycle(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 5) < 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
